// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache miss paths, the off-chip memory port and
// the arbiter. The arbiter takes the slave view; whatever surrounds it
// (caches plus memory model) takes the master view.
//
// Handshake: a cache raises its request (i_read / d_read / d_write) as a
// level together with address and data, and holds it until the matching
// *_ready pulse. A request counts only when the arbiter samples it in IDLE.
// Memory sees mem_read/mem_write as a level held until it answers with
// mem_ready, which carries mem_rdata on the same edge. *_ready is a single-cycle
// pulse, and the paired *_rdata is valid during that pulse.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;
  logic              timeout_err;
  logic [15:0]       busy_cycles;
  logic [1:0]        state_dbg;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr,
           mem_wdata, busy, timeout_err, busy_cycles, state_dbg
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr,
           mem_wdata, busy, timeout_err, busy_cycles, state_dbg
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing one off-chip memory port between the I-cache and
// D-cache. One transaction at a time, alternating grant on ties, registered
// memory command, one-cycle ready pulse, sticky watchdog and a saturating
// busy-cycle counter. state_dbg exposes the FSM state (0 IDLE, 1 SERVE_I,
// 2 SERVE_D, 3 DONE).
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2, DONE = 2'd3} state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

  state_t            state_q;
  logic              last_grant_q;  // 0: I-cache, 1: D-cache
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_ready_q;
  logic              d_ready_q;
  logic              timeout_err_q;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic [15:0]       busy_cycles_q;
  logic [15:0]       busy_cycles_d;
  logic              req_i;
  logic              req_d;
  logic              grant_i;
  logic              grant_d;

  // Grant decode: on a tie the side that did not win last time gets the port.
  always_comb begin
    req_i   = bus.i_read;
    req_d   = bus.d_read | bus.d_write;
    grant_d = req_d & (~req_i | ~last_grant_q);
    grant_i = req_i & ~grant_d;
  end

  // Next values for the watchdog and busy counters, both saturating.
  always_comb begin
    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    busy_cycles_d = busy_cycles_q;
    if (state_q != IDLE && busy_cycles_q != 16'hFFFF) begin
      busy_cycles_d = busy_cycles_q + 16'd1;
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_ready_q     <= 1'b0;
      d_ready_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_q        <= '0;
      busy_cycles_q <= '0;
    end else begin
      i_ready_q     <= 1'b0;
      d_ready_q     <= 1'b0;
      busy_cycles_q <= busy_cycles_d;
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (grant_d) begin
            // Read and write together is a write-back; the read is dropped.
            state_q      <= SERVE_D;
            last_grant_q <= 1'b1;
            mem_addr_q   <= bus.d_addr;
            mem_wdata_q  <= bus.d_wdata;
            mem_write_q  <= bus.d_write;
            mem_read_q   <= bus.d_read & ~bus.d_write;
          end else if (grant_i) begin
            state_q      <= SERVE_I;
            last_grant_q <= 1'b0;
            mem_addr_q   <= bus.i_addr;
            mem_read_q   <= 1'b1;
            mem_write_q  <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.mem_ready) begin
            if (state_q == SERVE_I) begin
              i_rdata_q <= bus.mem_rdata;
              i_ready_q <= 1'b1;
            end else begin
              if (mem_read_q) d_rdata_q <= bus.mem_rdata;
              d_ready_q <= 1'b1;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            state_q     <= DONE;
          end else begin
            // Flag once TIMEOUT cycles have passed without an answer; keep waiting.
            if (wait_q == WAIT_LAST) timeout_err_q <= 1'b1;
            wait_q <= wait_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.i_ready     = i_ready_q;
  assign bus.d_ready     = d_ready_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy_cycles = busy_cycles_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache and D-cache miss/write-back paths of the 5-stage RISC-V core.
- Grants one requester at a time and latches its command. Holds the memory handshake until the memory acknowledges, then returns read data with a one-cycle ready pulse.
- Alternates grants on simultaneous requests so neither cache starves.
- Provides a per-transaction watchdog and a saturating busy-cycle counter for the test bench.

Parameters:
ADDR_W, 28, memory block address width
DATA_W, 128, memory line width in bits
TIMEOUT, 1023, max cycles a transaction may wait for mem_ready before the error flag sets

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
i_read  input  1  I-cache line read request, level, held until i_ready
i_addr  input  ADDR_W  I-cache block address
i_rdata  output  DATA_W  line returned to I-cache
i_ready  output  1  one-cycle completion pulse to I-cache
d_read  input  1  D-cache line read request
d_write  input  1  D-cache write-back request
d_addr  input  ADDR_W  D-cache block address
d_wdata  input  DATA_W  D-cache write-back line
d_rdata  output  DATA_W  line returned to D-cache
d_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  memory read command, registered
mem_write  output  1  memory write command, registered
mem_addr  output  ADDR_W  memory address, registered
mem_wdata  output  DATA_W  memory write data, registered
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
mem_ready  input  1  memory completion, single- or multi-cycle high
busy  output  1  high whenever state is not IDLE
timeout_err  output  1  sticky: a transaction exceeded TIMEOUT cycles
busy_cycles  output  16  saturating count of cycles with busy=1

Behaviour:
- Reset (rst=0, asynchronous) drives:
  - state to IDLE and last_grant to I;
  - all mem_* outputs, i_ready, d_ready and timeout_err to 0;
  - i_rdata, d_rdata and busy_cycles to 0; wait counter to 0.
- Reset mid-transaction abandons the transaction. No ready pulse is produced afterwards.
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE:
  - Only I requests: go SERVE_I.
  - Only D requests (d_read|d_write): go SERVE_D.
  - Both request: grant the side opposite last_grant, so the first tie after reset goes to D.
  - On the transition, latch address, command and wdata into mem_* registers. mem_read/mem_write are therefore high starting the cycle after the request is sampled.
  - last_grant updates on every grant.
- d_read and d_write both high: treated as a write. mem_write=1, mem_read=0.
- SERVE_x:
  - Hold mem_* stable.
  - Requester input changes after the grant are ignored, including request withdrawal; the transaction still completes.
  - Increment the wait counter each cycle.
  - On mem_ready=1: capture mem_rdata into the granted side's rdata register (write: rdata unchanged), drop mem_read/mem_write to 0 in the next cycle, and go DONE.
- DONE:
  - Assert the granted side's ready for exactly this one cycle; its rdata is valid this cycle and holds until the next capture.
  - Ignore all requests; go IDLE.
  - The requester must drop its request in the ready cycle. If it is still high in IDLE, it is a new request.
- Minimum turnaround: request sampled in cycle N, mem cmd in N+1, mem_ready in N+1 gives ready in N+2 and re-arbitration in N+3.
- mem_ready while IDLE or DONE is ignored.
- Watchdog:
  - Wait counter clears on entering SERVE_x.
  - When it reaches TIMEOUT with no mem_ready, timeout_err sets and stays set until reset.
  - The transaction keeps waiting; there is no abort.
- busy_cycles increments every cycle busy=1 and saturates at 16'hFFFF.

Test Plan:
- Single I read at i_addr=28'h0000010; mem_ready after 3 cycles with mem_rdata=128'hDEAD... -> mem_read=1 and mem_addr=0x10 for 3 cycles; i_ready pulses 1 cycle with i_rdata=128'hDEAD...; d_ready stays 0.
- i_read and d_write asserted in the same cycle after reset -> D granted first: mem_write=1 with d_addr and d_wdata. Then I is served: mem_read with i_addr. Exactly one d_ready pulse, then one i_ready pulse.
- Both sides requesting continuously for 6 transactions -> grants alternate D,I,D,I,D,I.
- d_read and d_write both high -> mem_write=1, mem_read=0; d_rdata unchanged.
- mem_ready held low for TIMEOUT+1 cycles -> timeout_err=1 from cycle TIMEOUT and stays 1 after a later mem_ready completes the transfer; cleared only by rst=0.
- rst pulled low while in SERVE_I with mem_read=1 -> mem_read=0 and busy=0 immediately; no i_ready pulse after release; busy_cycles=0.
